// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state encoding, defaults and target compare for nonce_sweep_ctrl
// Contents: sweep_state_t state type and its constants, NONCE_WORD_DEFAULT, is_hit().
package sweep_pkg;

    typedef logic [3:0] sweep_state_t;

    localparam sweep_state_t ST_IDLE      = 4'd0;
    localparam sweep_state_t ST_WR_NONCE  = 4'd1;
    localparam sweep_state_t ST_LAUNCH    = 4'd2;
    localparam sweep_state_t ST_WAIT_LOW  = 4'd3;
    localparam sweep_state_t ST_WAIT_DONE = 4'd4;
    localparam sweep_state_t ST_RD_REQ    = 4'd5;
    localparam sweep_state_t ST_RD_WAIT   = 4'd6;
    localparam sweep_state_t ST_CHECK     = 4'd7;
    localparam sweep_state_t ST_FINISH    = 4'd8;

    localparam int NONCE_WORD_DEFAULT = 19;

    // A result word is a hit when it is strictly below the target (unsigned).
    function automatic logic is_hit(input logic [31:0] word, input logic [31:0] tgt);
        return word < tgt;
    endfunction

endpackage

// File: rtl/nonce_sweep_ctrl_if.sv
// rtl/nonce_sweep_ctrl_if.sv - hash core handshake and shared memory port bundle
// Signals: hash_start/hash_done core handshake; mem_sel/mem_we/mem_addr/mem_write_data/mem_read_data memory port.
// Modports: master = sweep controller, slave = core/memory side.
interface nonce_sweep_ctrl_if;

    logic        hash_start;
    logic        hash_done;
    logic        mem_sel;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output hash_start,
        output mem_sel,
        output mem_we,
        output mem_addr,
        output mem_write_data,
        input  hash_done,
        input  mem_read_data
    );

    modport slave (
        input  hash_start,
        input  mem_sel,
        input  mem_we,
        input  mem_addr,
        input  mem_write_data,
        output hash_done,
        output mem_read_data
    );

endinterface

// File: rtl/nonce_sweep_ctrl.sv
// rtl/nonce_sweep_ctrl.sv - sweeps a nonce range through the SHA-256 core and reports a hit
// Ports: clk, reset (sync, active-high); sweep_start/sweep_abort control; nonce_base, nonce_count,
//        target, message_addr, output_addr sweep setup; core (nonce_sweep_ctrl_if.master) core
//        handshake + shared memory port; busy, sweep_done, found, found_nonce, found_hash status.
// Option: NONCE_SWEEP_STATS_EN adds hashes_done[31:0], a saturating count of checked nonces.
module nonce_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int NONCE_WORD  = NONCE_WORD_DEFAULT,
    parameter bit STOP_ON_HIT = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sweep_start,
    input  logic                    sweep_abort,
    input  logic [31:0]             nonce_base,
    input  logic [31:0]             nonce_count,
    input  logic [31:0]             target,
    input  logic [15:0]             message_addr,
    input  logic [15:0]             output_addr,
    nonce_sweep_ctrl_if.master      core,
    output logic                    busy,
    output logic                    sweep_done,
    output logic                    found,
`ifdef NONCE_SWEEP_STATS_EN
    output logic [31:0]             hashes_done,
`endif
    output logic [31:0]             found_nonce,
    output logic [31:0]             found_hash
);

    sweep_state_t state;
    logic [31:0]  cur;
    logic [31:0]  remaining;
    logic [31:0]  target_q;
    logic [15:0]  msg_q;
    logic [15:0]  out_q;
    logic         abort_q;
    logic [31:0]  rd_word;
    logic         zero_done;
    logic         hit;

    assign hit = is_hit(rd_word, target_q);

`ifdef NONCE_SWEEP_STATS_EN
    logic [31:0] stats_q;
    assign hashes_done = stats_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stats_q <= '0;
        end else if (state == ST_IDLE && sweep_start) begin
            stats_q <= '0;
        end else if (state == ST_CHECK && stats_q != 32'hFFFF_FFFF) begin
            stats_q <= stats_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cur         <= '0;
            remaining   <= '0;
            target_q    <= '0;
            msg_q       <= '0;
            out_q       <= '0;
            abort_q     <= 1'b0;
            rd_word     <= '0;
            zero_done   <= 1'b0;
            found       <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
        end else begin
            zero_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sweep_start) begin
                        found <= 1'b0;
                        if (nonce_count == 32'd0) begin
                            // Empty sweep: report completion without touching memory.
                            zero_done <= 1'b1;
                        end else begin
                            cur       <= nonce_base;
                            remaining <= nonce_count;
                            target_q  <= target;
                            msg_q     <= message_addr;
                            out_q     <= output_addr;
                            abort_q   <= 1'b0;
                            state     <= ST_WR_NONCE;
                        end
                    end
                end
                ST_WR_NONCE:  state <= ST_LAUNCH;
                ST_LAUNCH:    state <= ST_WAIT_LOW;
                ST_WAIT_LOW:  if (!core.hash_done) state <= ST_WAIT_DONE;
                // The core writes its result as it re-enters idle, so the read is
                // issued one cycle after hash_done is seen high.
                ST_WAIT_DONE: if (core.hash_done) state <= ST_RD_REQ;
                ST_RD_REQ:    state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    rd_word <= core.mem_read_data;
                    state   <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (hit) begin
                        found       <= 1'b1;
                        found_nonce <= cur;
                        found_hash  <= rd_word;
                    end
                    cur       <= cur + 32'd1;
                    remaining <= remaining - 32'd1;
                    if (remaining == 32'd1 || (hit && STOP_ON_HIT) || abort_q) begin
                        state <= ST_FINISH;
                    end else begin
                        state <= ST_WR_NONCE;
                    end
                end
                ST_FINISH:    state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
            // Abort is sticky and only acted on at the next nonce boundary.
            if (busy && sweep_abort) begin
                abort_q <= 1'b1;
            end
        end
    end

    always_comb begin
        busy                = (state != ST_IDLE) && (state != ST_FINISH);
        sweep_done          = (state == ST_FINISH) || zero_done;
        core.hash_start     = (state == ST_LAUNCH);
        // The core owns memory only while it may be hashing.
        core.mem_sel        = !((state == ST_LAUNCH) || (state == ST_WAIT_LOW) ||
                                (state == ST_WAIT_DONE));
        core.mem_we         = (state == ST_WR_NONCE);
        core.mem_addr       = '0;
        core.mem_write_data = '0;
        if (state == ST_WR_NONCE) begin
            core.mem_addr       = msg_q + 16'(NONCE_WORD);
            core.mem_write_data = cur;
        end else if (state == ST_RD_REQ || state == ST_RD_WAIT) begin
            core.mem_addr       = out_q;
        end
    end

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// tb/tb_nonce_sweep_ctrl.sv - scoreboard bench: lane 0 STOP_ON_HIT=1, lane 1 STOP_ON_HIT=0
module tb_nonce_sweep_ctrl;

    typedef struct {
        logic        found;
        logic [31:0] nonce;
        logic [31:0] hash;
        int          pulses;
    } done_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sweep_start;
    logic        sweep_abort;
    logic [31:0] nonce_base;
    logic [31:0] nonce_count;
    logic [31:0] target;
    logic [15:0] message_addr;
    logic [15:0] output_addr;

    logic        busy_w[2];
    logic        done_w[2];
    logic        found_w[2];
    logic [31:0] fn_w[2];
    logic [31:0] fh_w[2];
    logic        sel_w[2];
    logic        we_w[2];
    logic        hs_w[2];
    logic [15:0] addr_w[2];
    logic        core_done_w[2];

    int n_checks = 0;
    int n_pass   = 0;
    bit sb_on    = 1'b1;

    logic [47:0] exp_wr[2][256];
    done_t       exp_dn[2][16];
    int          wr_head[2]    = '{0, 0};
    int          wr_tail[2]    = '{0, 0};
    int          dn_head[2]    = '{0, 0};
    int          dn_tail[2]    = '{0, 0};
    int          done_cnt[2]   = '{0, 0};
    int          tot_pulses[2] = '{0, 0};
    logic        exp_found[2];

    logic [31:0] ovr_val[8];
    logic [7:0]  ovr_en;
    logic [31:0] ovr_base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
    endtask

    // Behavioural core: chosen offsets from the sweep base return a table value,
    // everything else returns a scrambled word with the top bit set.
    function automatic logic [31:0] core_result(input logic [31:0] n);
        logic [31:0] off;
        off = n - ovr_base;
        if (off < 32'd8 && ovr_en[off[2:0]]) return ovr_val[off[2:0]];
        return 32'h8000_0000 | (n * 32'h9E37_79B1);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        nonce_sweep_ctrl_if bus();
        bit   [31:0] mem [65536];
        logic [31:0] rdata;
        logic        core_done;
        logic        core_wr;
        int          core_cnt;
        logic [31:0] core_res;
        int          pulses;
        logic [31:0] hashes_w;
        wire  [15:0] nonce_addr = message_addr + 16'd19;
        wire  [15:0] m_addr = bus.mem_sel ? bus.mem_addr : output_addr;
        wire         m_we   = bus.mem_sel ? bus.mem_we : core_wr;
        wire  [31:0] m_wd   = bus.mem_sel ? bus.mem_write_data : core_res;

        nonce_sweep_ctrl #(.STOP_ON_HIT((g == 0) ? 1'b1 : 1'b0)) dut (
            .clk          (clk),
            .reset        (reset),
            .sweep_start  (sweep_start),
            .sweep_abort  (sweep_abort),
            .nonce_base   (nonce_base),
            .nonce_count  (nonce_count),
            .target       (target),
            .message_addr (message_addr),
            .output_addr  (output_addr),
            .core         (bus.master),
            .busy         (busy_w[g]),
            .sweep_done   (done_w[g]),
            .found        (found_w[g]),
`ifdef NONCE_SWEEP_STATS_EN
            .hashes_done  (hashes_w),
`endif
            .found_nonce  (fn_w[g]),
            .found_hash   (fh_w[g])
        );

        assign bus.hash_done     = core_done;
        assign bus.mem_read_data = rdata;
        assign sel_w[g]          = bus.mem_sel;
        assign we_w[g]           = bus.mem_we;
        assign hs_w[g]           = bus.hash_start;
        assign addr_w[g]         = bus.mem_addr;
        assign core_done_w[g]    = core_done;

        always @(posedge clk) begin
            if (m_we) mem[m_addr] <= m_wd;
            rdata <= mem[m_addr];
        end

        // Core: done drops after start, stays low 1..3 cycles, then rises while the
        // result is written for one cycle.
        always @(posedge clk) begin
            if (reset) begin
                core_done <= 1'b1;
                core_wr   <= 1'b0;
                core_cnt  <= 0;
                core_res  <= '0;
            end else if (core_wr) begin
                core_wr <= 1'b0;
            end else if (core_cnt != 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1) begin
                    core_done <= 1'b1;
                    core_wr   <= 1'b1;
                end
            end else if (bus.hash_start) begin
                core_res  <= core_result(mem[nonce_addr]);
                core_cnt  <= 1 + int'(mem[nonce_addr] % 32'd3);
                core_done <= 1'b0;
            end
        end

        always @(negedge clk) begin
            if (reset) begin
                pulses <= 0;
            end else begin
                if (bus.hash_start) begin
                    pulses        <= pulses + 1;
                    tot_pulses[g] <= tot_pulses[g] + 1;
                end
                if (sb_on && bus.mem_sel && bus.mem_we) begin
                    chk($sformatf("lane%0d write_expected", g),
                        (wr_tail[g] != wr_head[g]) ? 32'd1 : 32'd0, 32'd1);
                    if (wr_tail[g] != wr_head[g]) begin
                        chk($sformatf("lane%0d write_addr", g), {16'd0, bus.mem_addr},
                            {16'd0, exp_wr[g][wr_head[g] % 256][47:32]});
                        chk($sformatf("lane%0d write_nonce", g), bus.mem_write_data,
                            exp_wr[g][wr_head[g] % 256][31:0]);
                        wr_head[g] <= wr_head[g] + 1;
                    end
                end
                if (sb_on && done_w[g]) begin
                    done_cnt[g] <= done_cnt[g] + 1;
                    pulses      <= 0;
                    chk($sformatf("lane%0d done_expected", g),
                        (dn_tail[g] != dn_head[g]) ? 32'd1 : 32'd0, 32'd1);
                    if (dn_tail[g] != dn_head[g]) begin
                        chk($sformatf("lane%0d found", g), {31'd0, found_w[g]},
                            {31'd0, exp_dn[g][dn_head[g] % 16].found});
                        chk($sformatf("lane%0d busy_at_done", g), {31'd0, busy_w[g]}, 32'd0);
                        chk($sformatf("lane%0d hash_starts", g), pulses,
                            exp_dn[g][dn_head[g] % 16].pulses);
`ifdef NONCE_SWEEP_STATS_EN
                        chk($sformatf("lane%0d hashes_done", g), hashes_w,
                            exp_dn[g][dn_head[g] % 16].pulses);
`endif
                        if (exp_dn[g][dn_head[g] % 16].found) begin
                            chk($sformatf("lane%0d found_nonce", g), fn_w[g],
                                exp_dn[g][dn_head[g] % 16].nonce);
                            chk($sformatf("lane%0d found_hash", g), fh_w[g],
                                exp_dn[g][dn_head[g] % 16].hash);
                        end
                        dn_head[g] <= dn_head[g] + 1;
                    end
                end
                if (core_wr) chk($sformatf("lane%0d mem_contention", g), {31'd0, bus.mem_sel}, 32'd0);
            end
        end
    end

    task automatic run_sweep(input logic [31:0] b, input logic [31:0] c, input logic [31:0] t,
                             input logic [15:0] ma, input logic [15:0] oa,
                             input int abort_k, input bit glitch);
        done_t       e;
        logic [31:0] n;
        logic [31:0] r;
        int          d0;
        int          d1;
        int          p0;
        int          k;
        ovr_base = b;
        for (int g = 0; g < 2; g++) begin
            e.found = 1'b0; e.nonce = '0; e.hash = '0; e.pulses = 0;
            for (longint i = 0; i < longint'(c); i++) begin
                n = b + 32'(i);
                r = core_result(n);
                exp_wr[g][wr_tail[g] % 256] = {ma + 16'd19, n};
                wr_tail[g]++;
                e.pulses++;
                if (r < t) begin
                    e.found = 1'b1; e.nonce = n; e.hash = r;
                end
                // lane 0 stops at its first hit; both honour abort after abort_k hashes
                if (r < t && g == 0) break;
                if (abort_k != 0 && e.pulses >= abort_k) break;
            end
            exp_dn[g][dn_tail[g] % 16] = e;
            dn_tail[g]++;
            exp_found[g] = e.found;
        end
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        p0 = tot_pulses[0];
        @(posedge clk); #1;
        nonce_base = b; nonce_count = c; target = t;
        message_addr = ma; output_addr = oa;
        sweep_start = 1'b1;
        @(posedge clk); #1;
        sweep_start = 1'b0;
        if (glitch) begin
            repeat (3) @(posedge clk);
            #1;
            nonce_base = ~b; nonce_count = 32'd1; target = 32'hFFFF_FFFF;
            sweep_start = 1'b1;
            @(posedge clk); #1;
            sweep_start = 1'b0;
        end
        if (abort_k != 0) begin
            k = 0;
            while (tot_pulses[0] < p0 + abort_k && k < 1000) begin
                @(posedge clk); #1;
                k++;
            end
            sweep_abort = 1'b1;
            @(posedge clk); #1;
            sweep_abort = 1'b0;
        end
        k = 0;
        while ((done_cnt[0] == d0 || done_cnt[1] == d1) && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("sweep_completes", (k < 3000) ? 32'd1 : 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("lane%0d found_held", g), {31'd0, found_w[g]}, {31'd0, exp_found[g]});
            chk($sformatf("lane%0d idle_busy", g), {31'd0, busy_w[g]}, 32'd0);
            chk($sformatf("lane%0d writes_left", g), wr_tail[g] - wr_head[g], 32'd0);
            chk($sformatf("lane%0d dones_left", g), dn_tail[g] - dn_head[g], 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int k;
        logic [31:0] rb;
        logic [31:0] rt;
        logic [15:0] rm;
        reset = 1'b1; sweep_start = 1'b0; sweep_abort = 1'b0;
        nonce_base = '0; nonce_count = '0; target = '0;
        message_addr = '0; output_addr = '0;
        ovr_en = '0; ovr_base = '0;
        for (int i = 0; i < 8; i++) ovr_val[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("lane%0d rst_busy", g), {31'd0, busy_w[g]}, 32'd0);
            chk($sformatf("lane%0d rst_done", g), {31'd0, done_w[g]}, 32'd0);
            chk($sformatf("lane%0d rst_found", g), {31'd0, found_w[g]}, 32'd0);
            chk($sformatf("lane%0d rst_found_nonce", g), fn_w[g], 32'd0);
            chk($sformatf("lane%0d rst_found_hash", g), fh_w[g], 32'd0);
            chk($sformatf("lane%0d rst_mem_sel", g), {31'd0, sel_w[g]}, 32'd1);
            chk($sformatf("lane%0d rst_mem_we", g), {31'd0, we_w[g]}, 32'd0);
            chk($sformatf("lane%0d rst_hash_start", g), {31'd0, hs_w[g]}, 32'd0);
            chk($sformatf("lane%0d rst_mem_addr", g), {16'd0, addr_w[g]}, 32'd0);
        end
        reset = 1'b0;

        // three misses, with a sweep_start while busy that must be ignored
        ovr_en = 8'h00;
        run_sweep(32'h10, 32'd3, 32'd0, 16'h0100, 16'h0200, 0, 1'b1);

        // single hit on the second nonce
        ovr_en = 8'b0000_0010; ovr_val[1] = 32'd5;
        run_sweep(32'h1234_5670, 32'd4, 32'h100, 16'h0300, 16'h0400, 0, 1'b0);

        // hits on the first and third of four nonces
        ovr_en = 8'b0000_0101; ovr_val[0] = 32'd7; ovr_val[2] = 32'd9;
        run_sweep(32'h0ABC_0000, 32'd4, 32'h100, 16'h0500, 16'h0600, 0, 1'b0);

        // nonce wraps 0xFFFFFFFF -> 0 and nonce address wraps past 0xFFFF
        ovr_en = 8'h00;
        run_sweep(32'hFFFF_FFFF, 32'd2, 32'h9000_0000, 16'hFFF0, 16'h0700, 0, 1'b0);

        // abort during the second of ten hashes
        ovr_en = 8'h00;
        run_sweep(32'h500, 32'd10, 32'd0, 16'h0800, 16'h0900, 2, 1'b0);

        // target all-ones: only a 0xFFFFFFFF result misses
        ovr_en = 8'b0000_0001; ovr_val[0] = 32'hFFFF_FFFF;
        run_sweep(32'h77, 32'd3, 32'hFFFF_FFFF, 16'h0A00, 16'h0B00, 0, 1'b0);

        // randomized sweeps
        for (int it = 0; it < 5; it++) begin
            ovr_en = 8'($urandom);
            for (int i = 0; i < 8; i++) ovr_val[i] = $urandom;
            rb = $urandom;
            rt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            rm = 16'($urandom);
            run_sweep(rb, 32'($urandom_range(1, 6)), rt, rm, rm + 16'h0100, 0, 1'b0);
        end

        // empty sweep: done the cycle after start, no writes, found cleared
        for (int g = 0; g < 2; g++) begin
            exp_dn[g][dn_tail[g] % 16] = '{found: 1'b0, nonce: 32'd0, hash: 32'd0, pulses: 0};
            dn_tail[g]++;
        end
        @(posedge clk); #1;
        nonce_count = 32'd0;
        sweep_start = 1'b1;
        @(posedge clk); #1;
        sweep_start = 1'b0;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("lane%0d zero_done", g), {31'd0, done_w[g]}, 32'd1);
            chk($sformatf("lane%0d zero_busy", g), {31'd0, busy_w[g]}, 32'd0);
        end
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("lane%0d zero_done_pulse", g), {31'd0, done_w[g]}, 32'd0);
            chk($sformatf("lane%0d zero_found", g), {31'd0, found_w[g]}, 32'd0);
            chk($sformatf("lane%0d zero_writes_left", g), wr_tail[g] - wr_head[g], 32'd0);
        end

        // reset while waiting for the core
        sb_on = 1'b0;
        nonce_base = 32'd2; nonce_count = 32'd10; target = 32'd0;
        message_addr = 16'h0C00; output_addr = 16'h0D00;
        sweep_start = 1'b1;
        @(posedge clk); #1;
        sweep_start = 1'b0;
        k = 0;
        while (core_done_w[0] && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("core_started", (k < 200) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("lane%0d midrst_busy", g), {31'd0, busy_w[g]}, 32'd0);
            chk($sformatf("lane%0d midrst_mem_sel", g), {31'd0, sel_w[g]}, 32'd1);
            chk($sformatf("lane%0d midrst_hash_start", g), {31'd0, hs_w[g]}, 32'd0);
            chk($sformatf("lane%0d midrst_done", g), {31'd0, done_w[g]}, 32'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        sb_on = 1'b1;

        // sweep after reset
        ovr_en = 8'h00;
        run_sweep(32'h20, 32'd2, 32'hFFFF_FFFF, 16'h0E00, 16'h0F00, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
